cla_slice_sequencer: RTL and testbench

//  Sequences one shared 4-bit registered CLA slice to add or subtract WIDTH-bit operands.
//  - Processes one nibble per step, LSB first, rippling the carry between steps.
//  - Sits between an operand source (valid/ready) and a result sink (valid/ready).
//  - The CLA slice is external; this block only drives it and captures its outputs.

---
 rtl/cla_slice_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_cla_slice_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_slice_sequencer.sv
// Drives one external 4-bit registered CLA slice nibble by nibble to add/subtract WIDTH-bit operands.
// Optional saturation of signed-overflowing results is enabled with `define CLA_SEQ_SAT_EN.
module cla_slice_sequencer #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned CLA_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
`ifdef CLA_SEQ_SAT_EN
   input  logic             in_sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy,
   output logic [3:0]       cla_a,
   output logic [3:0]       cla_b,
   output logic             cla_cin,
   input  logic [3:0]       cla_s,
   input  logic             cla_cout
);

   localparam int unsigned NSL   = WIDTH / 4;
   localparam int unsigned IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
   localparam int unsigned CNT_W = (CLA_LAT > 0) ? $clog2(CLA_LAT + 1) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SLICE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]            state_q, state_nxt;
   logic [NSL-1:0][3:0]   a_q, a_nxt;
   logic [NSL-1:0][3:0]   b_q, b_nxt;
   logic [NSL-1:0][3:0]   sum_q, sum_nxt;
   logic [IDX_W-1:0]      idx_q, idx_nxt;
   logic [CNT_W-1:0]      cnt_q, cnt_nxt;
   logic                  cout_nxt;
   logic                  ovf_nxt;
   logic                  valid_nxt;
   logic                  ready_nxt;
   logic                  busy_nxt;
   logic [3:0]            cla_a_nxt;
   logic [3:0]            cla_b_nxt;
   logic                  cla_cin_nxt;
   logic                  ovf_c;
   logic [WIDTH-1:0]      b_eff;
`ifdef CLA_SEQ_SAT_EN
   logic                  sat_q, sat_nxt;
`endif

   // Subtraction is A + ~B + 1: invert B here, the +1 enters as the first carry-in.
   assign b_eff   = in_b ^ {WIDTH{in_sub}};
   assign out_sum = sum_q;

   // Next-state and next-output logic.
   always_comb begin
      state_nxt   = state_q;
      a_nxt       = a_q;
      b_nxt       = b_q;
      sum_nxt     = sum_q;
      idx_nxt     = idx_q;
      cnt_nxt     = cnt_q;
      cout_nxt    = out_cout;
      ovf_nxt     = out_ovf;
      valid_nxt   = out_valid;
      ready_nxt   = in_ready;
      busy_nxt    = busy;
      cla_a_nxt   = cla_a;
      cla_b_nxt   = cla_b;
      cla_cin_nxt = cla_cin;
      ovf_c       = 1'b0;
`ifdef CLA_SEQ_SAT_EN
      sat_nxt     = sat_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_nxt       = in_a;
               b_nxt       = b_eff;
               cla_a_nxt   = in_a[3:0];
               cla_b_nxt   = b_eff[3:0];
               cla_cin_nxt = in_sub;
               idx_nxt     = '0;
               cnt_nxt     = '0;
               ready_nxt   = 1'b0;
               busy_nxt    = 1'b1;
               state_nxt   = S_SLICE;
`ifdef CLA_SEQ_SAT_EN
               sat_nxt     = in_sat;
`endif
            end
         end

         S_SLICE: begin
            if (cnt_q == CNT_W'(CLA_LAT)) begin
               // Slice output is settled: capture it and ripple the carry into the next step.
               cnt_nxt        = '0;
               sum_nxt[idx_q] = cla_s;
               cla_cin_nxt    = cla_cout;
               if (idx_q == IDX_W'(NSL - 1)) begin
                  ovf_c = (a_q[NSL-1][3] == b_q[NSL-1][3]) && (cla_s[3] != a_q[NSL-1][3]);
`ifdef CLA_SEQ_SAT_EN
                  if (sat_q && ovf_c)
                     sum_nxt = a_q[NSL-1][3] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                  ovf_nxt     = ovf_c;
                  cout_nxt    = cla_cout;
                  valid_nxt   = 1'b1;
                  cla_a_nxt   = '0;
                  cla_b_nxt   = '0;
                  cla_cin_nxt = 1'b0;
                  state_nxt   = S_DONE;
               end else begin
                  idx_nxt   = idx_q + IDX_W'(1);
                  cla_a_nxt = a_q[idx_nxt];
                  cla_b_nxt = b_q[idx_nxt];
               end
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end

         S_DONE: begin
            if (out_ready) begin
               valid_nxt = 1'b0;
               busy_nxt  = 1'b0;
               ready_nxt = 1'b1;
               state_nxt = S_IDLE;
            end
         end

         default: begin
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            ready_nxt = 1'b1;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         cla_a     <= '0;
         cla_b     <= '0;
         cla_cin   <= 1'b0;
`ifdef CLA_SEQ_SAT_EN
         sat_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_nxt;
         a_q       <= a_nxt;
         b_q       <= b_nxt;
         sum_q     <= sum_nxt;
         idx_q     <= idx_nxt;
         cnt_q     <= cnt_nxt;
         out_cout  <= cout_nxt;
         out_ovf   <= ovf_nxt;
         out_valid <= valid_nxt;
         in_ready  <= ready_nxt;
         busy      <= busy_nxt;
         cla_a     <= cla_a_nxt;
         cla_b     <= cla_b_nxt;
         cla_cin   <= cla_cin_nxt;
`ifdef CLA_SEQ_SAT_EN
         sat_q     <= sat_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Bench for cla_slice_sequencer (WIDTH=16, CLA_LAT=2) with a two-stage behavioural CLA slice.
// Directed table, multi-cycle corner sequences, then random ops against an arithmetic model.
module tb_cla_slice_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_sub;
`ifdef CLA_SEQ_SAT_EN
   logic        in_sat;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_cout;
   logic        out_ovf;
   logic        busy;
   logic [3:0]  cla_a;
   logic [3:0]  cla_b;
   logic        cla_cin;
   logic [3:0]  cla_s;
   logic        cla_cout;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cla_slice_sequencer #(.WIDTH(16), .CLA_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
`ifdef CLA_SEQ_SAT_EN
      .in_sat(in_sat),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy),
      .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
      .cla_s(cla_s), .cla_cout(cla_cout)
   );

   // External slice: result appears two edges after its inputs.
   logic [4:0] p1, p2;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= '0;
         p2 <= '0;
      end else begin
         p1 <= {1'b0, cla_a} + {1'b0, cla_b} + 5'(cla_cin);
         p2 <= p1;
      end
   end
   assign cla_s    = p2[3:0];
   assign cla_cout = p2[4];

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic        sat;
      logic [15:0] s;
      logic        co;
      logic        ov;
      int          hold;
      bit          pulse;
   } vec_t;

   vec_t tbl[$];

   function automatic void add_vec(input string name, input logic [15:0] a, b, input logic sub, sat,
                                   input logic [15:0] s, input logic co, ov, input int hold, input bit pulse);
      vec_t v;
      v.name = name; v.a = a; v.b = b; v.sub = sub; v.sat = sat;
      v.s = s; v.co = co; v.ov = ov; v.hold = hold; v.pulse = pulse;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: signed/unsigned arithmetic on whole words. Returns {ovf, cout, sum}.
   function automatic logic [17:0] ref_op(input logic [15:0] a, b, input logic sub, sat);
      logic [15:0] bb;
      logic [16:0] full;
      logic [15:0] sum;
      int          r;
      logic        ovf;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + 17'(sub);
      r    = sub ? ($signed(a) - $signed(b)) : ($signed(a) + $signed(b));
      ovf  = (r > 32767) || (r < -32768);
      sum  = full[15:0];
      if (sat && ovf) sum = (r > 0) ? 16'h7FFF : 16'h8000;
      return {ovf, full[16], sum};
   endfunction

   // Carry entering nibble k = carry out of the low 4k bits of the full addition.
   function automatic logic carry_into(input logic [15:0] a, b, input logic sub, input int k);
      logic [15:0] bb;
      logic [16:0] m, lo;
      bb = sub ? ~b : b;
      m  = (17'd1 << (4 * k)) - 17'd1;
      lo = ({1'b0, a} & m) + ({1'b0, bb} & m) + 17'(sub);
      return lo[4*k];
   endfunction

   task automatic run_op(input string tag, input logic [15:0] a, b, input logic sub,
                         input logic [15:0] es, input logic eco, eov, input int hold, input bit pulse);
      logic [15:0] bb;
      logic [3:0]  tr_a[4];
      logic [3:0]  tr_b[4];
      logic        tr_c[4];
      logic [15:0] anib, bnib;
      int          lat;
      bb = sub ? ~b : b;
      in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("%s_accept", tag), {in_ready, busy}, 2'b01);
      lat = 0;
      while (!out_valid && lat < 200) begin
         if (lat % 3 == 0 && lat < 12) begin
            tr_a[lat/3] = cla_a;
            tr_b[lat/3] = cla_b;
            tr_c[lat/3] = cla_cin;
         end
         if (pulse && lat == 4) begin
            in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001; in_sub = 1'b0;
         end
         if (lat == 5) in_valid = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) begin
         check($sformatf("%s_timeout", tag), 32'(out_valid), 32'd1);
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         return;
      end
      check($sformatf("%s_latency", tag), 32'(lat), 32'd12);
      for (int k = 0; k < 4; k++) begin
         anib = a >> (4 * k);
         bnib = bb >> (4 * k);
         check($sformatf("%s_slice%0d", tag, k), {tr_a[k], tr_b[k], tr_c[k]},
               {anib[3:0], bnib[3:0], carry_into(a, b, sub, k)});
      end
      check($sformatf("%s_sum", tag), 32'(out_sum), 32'(es));
      check($sformatf("%s_flags", tag), {out_cout, out_ovf}, {eco, eov});
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check($sformatf("%s_hold%0d", tag, h), {out_valid, in_ready, busy, out_cout, out_ovf, out_sum},
               {1'b1, 1'b0, 1'b1, eco, eov, es});
      end
      out_ready = 1'b1;
      if (hold > 0) begin
         in_valid = 1'b1; in_a = 16'h0F0F; in_b = 16'h0101; in_sub = 1'b0;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check($sformatf("%s_release", tag), {out_valid, in_ready, busy}, 3'b010);
      check($sformatf("%s_idle_sum", tag), {out_cout, out_ovf, out_sum}, {eco, eov, es});
   endtask

   initial begin
      logic [17:0] exp;
      logic [15:0] ra, rb;
      logic        rsub, rsat;

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
`ifdef CLA_SEQ_SAT_EN
      in_sat = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset", {in_ready, out_valid, busy, out_cout, out_ovf, out_sum, cla_a, cla_b, cla_cin},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0});
      rst_n = 1'b1;
      @(posedge clk); #1;

      add_vec("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 5, 1'b0);
      add_vec("addffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
      add_vec("sub8000", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0, 1'b0);
      add_vec("add7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1, 1'b0);
      add_vec("sub5m3",  16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 0, 1'b0);
      add_vec("sub3m5",  16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 2, 1'b0);
      add_vec("sub0m0",  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
      add_vec("addneg",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
      add_vec("ignore",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b1);
`ifdef CLA_SEQ_SAT_EN
      add_vec("sat8000", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 0, 1'b0);
      add_vec("sat7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 0, 1'b0);
      add_vec("satneg",  16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 0, 1'b0);
      add_vec("satnov",  16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 0, 1'b0);
`endif

      foreach (tbl[i]) begin
`ifdef CLA_SEQ_SAT_EN
         in_sat = tbl[i].sat;
`endif
         run_op(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].s, tbl[i].co, tbl[i].ov,
                tbl[i].hold, tbl[i].pulse);
      end

      // Abort an operation with reset at its fifth edge.
`ifdef CLA_SEQ_SAT_EN
      in_sat = 1'b0;
`endif
      in_a = 16'h1234; in_b = 16'h4321; in_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort", {in_ready, out_valid, busy, cla_a, cla_b, cla_cin, out_sum},
            {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 16'h0000});
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rsub = 1'($urandom_range(0, 1));
         rsat = 1'b0;
`ifdef CLA_SEQ_SAT_EN
         rsat   = 1'($urandom_range(0, 1));
         in_sat = rsat;
`endif
         exp = ref_op(ra, rb, rsub, rsat);
         run_op($sformatf("rnd%0d", n), ra, rb, rsub, exp[15:0], exp[16], exp[17],
                int'($urandom_range(0, 3)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
